uart_tx_engine: RTL and testbench



---
 rtl/uart_tx_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit engine with a valid/ready byte interface.
// Selector encodings match the receive path (bd_sel, prty_sel, stop_sel, data_bit_sel).
// Optional feature macro: UART_TX_BREAK_EN adds a send_break input that holds the
// line low for at least 11 bit times while it is asserted in IDLE.
module uart_tx_engine #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bd_sel,
    input  logic [1:0] prty_sel,
    input  logic       stop_sel,
    input  logic       data_bit_sel,
    input  logic [7:0] data_in,
    input  logic       tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic       send_break,
`endif
    output logic       tx_ready,
    output logic       data_ser,
    output logic       baud_tick,
    output logic       tx_done
);

    // Rounded cycles-per-bit for each supported baud rate
    localparam int unsigned DIV_1200 = (CLK_FREQ + 600) / 1200;
    localparam int unsigned DIV_2400 = (CLK_FREQ + 1200) / 2400;
    localparam int unsigned DIV_4800 = (CLK_FREQ + 2400) / 4800;
    localparam int unsigned DIV_9600 = (CLK_FREQ + 4800) / 9600;
`ifdef UART_TX_BREAK_EN
    localparam int unsigned BRK_BITS = 11;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BRK
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   div_val_q, div_val_d;
    logic [DIV_W-1:0]   sel_div_c;
    logic [2:0]         bit_q, bit_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               seven_q, seven_d;
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;
    logic               stop2_q, stop2_d;
    logic               tx_ready_d, data_ser_d, baud_tick_d, tx_done_d;
    logic               bit_end_c;
    logic [2:0]         last_bit_c;
`ifdef UART_TX_BREAK_EN
    logic [3:0]         brk_cnt_q, brk_cnt_d;
`endif

    // Divisor lookup from the live baud selector (sampled only on accept)
    always_comb begin
        sel_div_c = DIV_W'(DIV_1200);
        case (bd_sel)
            2'b00:   sel_div_c = DIV_W'(DIV_1200);
            2'b01:   sel_div_c = DIV_W'(DIV_2400);
            2'b10:   sel_div_c = DIV_W'(DIV_4800);
            default: sel_div_c = DIV_W'(DIV_9600);
        endcase
    end

    assign bit_end_c  = (div_q == (div_val_q - DIV_W'(1)));
    assign last_bit_c = seven_q ? 3'd6 : 3'd7;

    // Next-state, divider/bit counters and next registered outputs
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        div_val_d   = div_val_q;
        bit_d       = bit_q;
        stop_cnt_d  = stop_cnt_q;
        shreg_d     = shreg_q;
        seven_d     = seven_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        tx_ready_d  = tx_ready;
        data_ser_d  = 1'b1;
        baud_tick_d = 1'b0;
        tx_done_d   = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_cnt_d   = brk_cnt_q;
`endif

        if (state_q != IDLE) begin
            div_d       = bit_end_c ? '0 : div_q + DIV_W'(1);
            baud_tick_d = bit_end_c;
        end

        case (state_q)
            IDLE: begin
                data_ser_d = 1'b1;
                tx_ready_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (send_break && tx_ready) begin
                    state_d    = BRK;
                    tx_ready_d = 1'b0;
                    div_d      = '0;
                    div_val_d  = sel_div_c;
                    brk_cnt_d  = 4'd0;
                end else
`endif
                if (tx_valid && tx_ready) begin
                    state_d    = START;
                    tx_ready_d = 1'b0;
                    div_d      = '0;
                    div_val_d  = sel_div_c;
                    bit_d      = 3'd0;
                    stop_cnt_d = 1'b0;
                    shreg_d    = data_in;
                    seven_d    = data_bit_sel;
                    par_en_d   = (prty_sel == 2'b01) || (prty_sel == 2'b10);
                    par_bit_d  = (data_bit_sel ? ^data_in[6:0] : ^data_in)
                                 ^ (prty_sel == 2'b10);
                    stop2_d    = stop_sel;
                end
            end
            START: begin
                data_ser_d = 1'b0;
                if (bit_end_c) state_d = DATA;
            end
            DATA: begin
                data_ser_d = shreg_q[bit_q];
                if (bit_end_c) begin
                    if (bit_q == last_bit_c) state_d = par_en_q ? PARITY : STOP;
                    else                     bit_d   = bit_q + 3'd1;
                end
            end
            PARITY: begin
                data_ser_d = par_bit_q;
                if (bit_end_c) state_d = STOP;
            end
            STOP: begin
                data_ser_d = 1'b1;
                if (bit_end_c) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        tx_done_d  = 1'b1;
                        tx_ready_d = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                data_ser_d = 1'b0;
                if (bit_end_c) begin
                    if (brk_cnt_q != 4'(BRK_BITS - 1)) begin
                        brk_cnt_d = brk_cnt_q + 4'd1;
                    end else if (!send_break) begin
                        state_d    = IDLE;
                        tx_ready_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                tx_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            div_val_q  <= '0;
            bit_q      <= 3'd0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= 8'd0;
            seven_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_ready   <= 1'b1;
            data_ser   <= 1'b1;
            baud_tick  <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q  <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            div_val_q  <= div_val_d;
            bit_q      <= bit_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            seven_q    <= seven_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_ready   <= tx_ready_d;
            data_ser   <= data_ser_d;
            baud_tick  <= baud_tick_d;
            tx_done    <= tx_done_d;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q  <= brk_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine; a reduced CLK_FREQ of 96000 gives
// 80/40/20/10 cycles per bit for bd_sel 00/01/10/11.
module tb_uart_tx_engine;

    localparam int unsigned CLK_FREQ = 96000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] bd_sel;
    logic [1:0] prty_sel;
    logic       stop_sel;
    logic       data_bit_sel;
    logic [7:0] data_in;
    logic       tx_valid;
    logic       tx_ready;
    logic       data_ser;
    logic       baud_tick;
    logic       tx_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(
        .CLK_FREQ(CLK_FREQ),
        .DIV_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bd_sel      (bd_sel),
        .prty_sel    (prty_sel),
        .stop_sel    (stop_sel),
        .data_bit_sel(data_bit_sel),
        .data_in     (data_in),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .data_ser    (data_ser),
        .baud_tick   (baud_tick),
        .tx_done     (tx_done)
    );

    // exp holds the line bits in send order, first bit at exp[11]
    typedef struct {
        logic [1:0]  bd;
        logic [1:0]  prty;
        logic        stop;
        logic        seven;
        logic [7:0]  data;
        logic [11:0] exp;
        int          n;
        int          div;
        logic        chg;
        logic        hold;
        logic [7:0]  nxt;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [1:0] bd, input logic [1:0] prty,
                                input logic stop, input logic seven,
                                input logic [7:0] data, input logic [11:0] exp,
                                input int n, input int div, input logic chg,
                                input logic hold, input logic [7:0] nxt);
        vec_t v;
        v.bd = bd; v.prty = prty; v.stop = stop; v.seven = seven; v.data = data;
        v.exp = exp; v.n = n; v.div = div; v.chg = chg; v.hold = hold; v.nxt = nxt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Send one frame and check line bits, tick count and tx_done timing
    task automatic run_frame(input vec_t v, input string tag);
        int f;
        int done_t;
        int done_cnt;
        int tick_cnt;
        int bit_i;
        f = v.n * v.div;
        bd_sel = v.bd; prty_sel = v.prty; stop_sel = v.stop;
        data_bit_sel = v.seven; data_in = v.data; tx_valid = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s ready_low_after_accept", tag), 32'(tx_ready), 32'd0);
        check($sformatf("%s line_high_at_accept", tag), 32'(data_ser), 32'd1);
        if (v.hold) data_in = v.nxt;
        else        tx_valid = 1'b0;
        done_t = -1; done_cnt = 0; tick_cnt = 0;
        for (int t = 1; t <= f; t++) begin
            @(posedge clk); #1;
            if (baud_tick) tick_cnt++;
            if (tx_done) begin done_cnt++; done_t = t; end
            if (t == 1) check($sformatf("%s start_edge", tag), 32'(data_ser), 32'd0);
            if (((t - 1) % v.div) == (v.div / 2)) begin
                bit_i = (t - 1) / v.div;
                check($sformatf("%s bit%0d", tag, bit_i), 32'(data_ser), 32'(v.exp[11 - bit_i]));
            end
            if (v.chg && t == 3 * v.div) begin
                bd_sel = ~v.bd; prty_sel = 2'b00; stop_sel = ~v.stop;
                data_bit_sel = ~v.seven; data_in = 8'hFF; tx_valid = 1'b1;
            end
            if (v.chg && t == 3 * v.div + 5) tx_valid = 1'b0;
        end
        check($sformatf("%s tick_count", tag), 32'(tick_cnt), 32'(v.n));
        check($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
        check($sformatf("%s done_cycle", tag), 32'(done_t), 32'(f));
        check($sformatf("%s ready_at_done", tag), 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int toggles;
        int lows;
        int dones;
        logic prev;
        vec_t r;

        vecs[0] = mk(2'b00, 2'b00, 1'b0, 1'b0, 8'h2D, 12'b010110100100, 10, 80, 1'b0, 1'b0, 8'h00);
        vecs[1] = mk(2'b11, 2'b01, 1'b1, 1'b0, 8'h2D, 12'b010110100011, 12, 10, 1'b0, 1'b0, 8'h00);
        vecs[2] = mk(2'b11, 2'b10, 1'b1, 1'b0, 8'h2D, 12'b010110100111, 12, 10, 1'b0, 1'b0, 8'h00);
        vecs[3] = mk(2'b01, 2'b10, 1'b0, 1'b1, 8'h2D, 12'b010110101100, 10, 40, 1'b1, 1'b0, 8'h00);
        vecs[4] = mk(2'b10, 2'b00, 1'b0, 1'b0, 8'h2D, 12'b010110100100, 10, 20, 1'b0, 1'b1, 8'hA5);
        vecs[5] = mk(2'b10, 2'b00, 1'b0, 1'b0, 8'hA5, 12'b010100101100, 10, 20, 1'b0, 1'b0, 8'h00);
        vecs[6] = mk(2'b11, 2'b11, 1'b0, 1'b0, 8'hFF, 12'b011111111100, 10, 10, 1'b0, 1'b0, 8'h00);
        vecs[7] = mk(2'b11, 2'b01, 1'b0, 1'b1, 8'h80, 12'b000000000100, 10, 10, 1'b0, 1'b0, 8'h00);

        rst = 1'b1; tx_valid = 1'b0; bd_sel = 2'b00; prty_sel = 2'b00;
        stop_sel = 1'b0; data_bit_sel = 1'b0; data_in = 8'h00;

        // Reset values and quiet idle line
        repeat (3) @(posedge clk);
        #1;
        check("reset data_ser", 32'(data_ser), 32'd1);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset tx_done", 32'(tx_done), 32'd0);
        check("reset baud_tick", 32'(baud_tick), 32'd0);
        rst = 1'b0;
        toggles = 0; prev = data_ser;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (data_ser !== prev || tx_ready !== 1'b1 || baud_tick !== 1'b0 || tx_done !== 1'b0)
                toggles++;
            prev = data_ser;
        end
        check("idle no activity", 32'(toggles), 32'd0);

        // Directed frame table
        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Reset during the 4th data bit abandons the frame
        repeat (3) @(posedge clk);
        #1;
        bd_sel = 2'b11; prty_sel = 2'b00; stop_sel = 1'b0; data_bit_sel = 1'b0;
        data_in = 8'h00; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        check("midrst line low before reset", 32'(data_ser), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst data_ser", 32'(data_ser), 32'd1);
        check("midrst tx_ready", 32'(tx_ready), 32'd1);
        check("midrst tx_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        lows = 0; dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (data_ser !== 1'b1) lows++;
            if (tx_done !== 1'b0) dones++;
        end
        check("midrst line stays idle", 32'(lows), 32'd0);
        check("midrst no done", 32'(dones), 32'd0);

        // Reset and tx_valid on the same edge: nothing accepted
        data_in = 8'h2D; tx_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0; rst = 1'b0;
        check("rst_vs_valid tx_ready", 32'(tx_ready), 32'd1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (data_ser !== 1'b1 || tx_ready !== 1'b1) lows++;
        end
        check("rst_vs_valid stays idle", 32'(lows), 32'd0);

        // A clean frame after the abandoned one
        r = vecs[0];
        r.bd = 2'b11;
        r.div = 10;
        run_frame(r, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
